// File: rtl/jpeg_stream_ctrl.sv
// jpeg_stream_ctrl -- front-end sequencer for the JPEG decode pipeline.
//
// Takes entropy-coded scan bytes over a ready/valid handshake, strips 0xFF00
// stuffing, skips 0xFF fill bytes and reacts to markers. Data bytes are sent
// to the decoder's 1-bit serial input MSB first. Rows returned by the decoder
// are counted into 8-row blocks so the controller knows when a frame has
// fully drained. Done and error are reported to the host FSM.
//
// Optional feature macro: JPEG_RST_MARKER_EN
//   defined   : RSTn markers (0xD0-0xD7) pulse resync_out and decoding goes on.
//               A marker whose n differs from the expected one sets error_out.
//   undefined : RSTn is an unknown marker (error, DONE). resync_out is 0.
//
// Ports:
//   clk_in            system clock
//   rst_in            synchronous active-high reset
//   start_in          begin a frame (acted on only in IDLE or DONE)
//   byte_in           scan data byte
//   byte_valid_in     byte_in valid
//   byte_ready_out    controller can accept a byte (registered)
//   serial_out        bit to decoder serial_in
//   serial_valid_out  serial_out valid
//   row_valid_in      decoder row strobe (one row per pulse)
//   block_count_out   blocks returned this frame (saturating)
//   busy_out          state is neither IDLE nor DONE
//   done_out          high while in DONE
//   error_out         sticky error flag, cleared by start
//   resync_out        one-cycle pulse per RSTn marker (feature only)

module jpeg_stream_ctrl #(
    parameter int BLOCKS_PER_FRAME = 1200,
    parameter int DRAIN_TIMEOUT    = 65535,
    parameter int CW               = 16
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          start_in,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid_in,
    output logic          byte_ready_out,
    output logic          serial_out,
    output logic          serial_valid_out,
    input  logic          row_valid_in,
    output logic [CW-1:0] block_count_out,
    output logic          busy_out,
    output logic          done_out,
    output logic          error_out,
    output logic          resync_out
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_MARKER = 3'd2;
    localparam logic [2:0] S_SHIFT  = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [CW-1:0] BPF_C    = CW'(BLOCKS_PER_FRAME);
    localparam logic [CW-1:0] TMO_LAST = CW'(DRAIN_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [2:0]    state, state_nxt;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic [2:0]    row_cnt;
    logic [CW-1:0] block_cnt;
    logic [CW-1:0] tmo_cnt;
    logic          error_q;
    logic          ready_q;

    logic          xfer;
    logic          load_sh;
    logic [7:0]    sh_val;
    logic          set_err;
    logic          clr;

`ifdef JPEG_RST_MARKER_EN
    logic          rst_mk;
    logic          resync_q;
    logic [2:0]    exp_n;
`endif

    assign xfer = byte_valid_in && ready_q;

    always_comb begin
        state_nxt = state;
        load_sh   = 1'b0;
        sh_val    = byte_in;
        set_err   = 1'b0;
        clr       = 1'b0;
`ifdef JPEG_RST_MARKER_EN
        rst_mk    = 1'b0;
`endif
        case (state)
            S_IDLE, S_DONE: begin
                if (start_in) begin
                    clr       = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    if (byte_in == 8'hFF) begin
                        state_nxt = S_MARKER;
                    end else begin
                        load_sh   = 1'b1;
                        state_nxt = S_SHIFT;
                    end
                end
            end
            S_MARKER: begin
                if (xfer) begin
                    case (byte_in) inside
                        8'h00: begin
                            // stuffed data byte: the 0xFF itself is the data
                            load_sh   = 1'b1;
                            sh_val    = 8'hFF;
                            state_nxt = S_SHIFT;
                        end
                        8'hFF: state_nxt = S_MARKER;   // fill byte
                        8'hD9: state_nxt = S_DRAIN;    // EOI
`ifdef JPEG_RST_MARKER_EN
                        [8'hD0:8'hD7]: begin
                            rst_mk    = 1'b1;
                            set_err   = (byte_in[2:0] != exp_n);
                            state_nxt = S_LOAD;
                        end
`endif
                        default: begin
                            set_err   = 1'b1;
                            state_nxt = S_DONE;
                        end
                    endcase
                end
            end
            S_SHIFT: begin
                if (bit_cnt == 3'd7)
                    state_nxt = S_LOAD;
            end
            S_DRAIN: begin
                // block count wins over a simultaneous timeout
                if (block_cnt == BPF_C) begin
                    state_nxt = S_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    set_err   = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= S_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            row_cnt   <= '0;
            block_cnt <= '0;
            tmo_cnt   <= '0;
            error_q   <= 1'b0;
            ready_q   <= 1'b0;
`ifdef JPEG_RST_MARKER_EN
            resync_q  <= 1'b0;
            exp_n     <= '0;
`endif
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt == S_LOAD) || (state_nxt == S_MARKER);

            if (load_sh) begin
                shreg   <= sh_val;
                bit_cnt <= '0;
            end else if (state == S_SHIFT) begin
                shreg   <= {shreg[6:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (state == S_DRAIN)
                tmo_cnt <= tmo_cnt + CNT_ONE;
            else
                tmo_cnt <= '0;

`ifdef JPEG_RST_MARKER_EN
            resync_q <= rst_mk;
`endif

            // A row arriving with the clearing start is dropped.
            if (clr) begin
                row_cnt   <= '0;
                block_cnt <= '0;
                error_q   <= 1'b0;
`ifdef JPEG_RST_MARKER_EN
                exp_n     <= '0;
`endif
            end else begin
                if (set_err)
                    error_q <= 1'b1;
`ifdef JPEG_RST_MARKER_EN
                if (rst_mk)
                    exp_n <= exp_n + 3'd1;
`endif
                // Counting runs during SHIFT too: the pipeline overlaps
                // input and output.
                if (state != S_IDLE && row_valid_in) begin
                    row_cnt <= row_cnt + 3'd1;
                    if (row_cnt == 3'd7 && block_cnt != '1)
                        block_cnt <= block_cnt + CNT_ONE;
                end
            end
        end
    end

    assign byte_ready_out   = ready_q;
    assign serial_valid_out = (state == S_SHIFT);
    assign serial_out       = (state == S_SHIFT) && shreg[7];
    assign block_count_out  = block_cnt;
    assign busy_out         = (state != S_IDLE) && (state != S_DONE);
    assign done_out         = (state == S_DONE);
    assign error_out        = error_q;
`ifdef JPEG_RST_MARKER_EN
    assign resync_out       = resync_q;
`else
    assign resync_out       = 1'b0;
`endif

endmodule

// File: tb/tb_jpeg_stream_ctrl.sv
// Self-checking bench for jpeg_stream_ctrl (BLOCKS_PER_FRAME=2,
// DRAIN_TIMEOUT=20). Serial bits are predicted into a queue when a byte is
// driven and popped by a negedge monitor as the DUT shifts them out.
module tb_jpeg_stream_ctrl;
    localparam int CW  = 16;
    localparam int BPF = 2;
    localparam int TMO = 20;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          start_in = 1'b0;
    logic [7:0]    byte_in = 8'h00;
    logic          byte_valid_in = 1'b0;
    logic          row_valid_in = 1'b0;
    logic          byte_ready_out, serial_out, serial_valid_out;
    logic [CW-1:0] block_count_out;
    logic          busy_out, done_out, error_out, resync_out;

    jpeg_stream_ctrl #(.BLOCKS_PER_FRAME(BPF), .DRAIN_TIMEOUT(TMO), .CW(CW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
        .byte_in(byte_in), .byte_valid_in(byte_valid_in),
        .byte_ready_out(byte_ready_out), .serial_out(serial_out),
        .serial_valid_out(serial_valid_out), .row_valid_in(row_valid_in),
        .block_count_out(block_count_out), .busy_out(busy_out),
        .done_out(done_out), .error_out(error_out), .resync_out(resync_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [7:0] b;
        bit         emits;
        logic [7:0] val;
    } vec_t;

    vec_t vecs[7];
    bit   exp_q[$];
    int   first_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   run = 0;
    int   resync_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit emits, input logic [7:0] val);
        int n = 0;
        byte_in = b;
        byte_valid_in = 1'b1;
        while (!byte_ready_out && n < 50) begin
            tick();
            n++;
        end
        if (!byte_ready_out) begin
            check("byte_ready_timeout", byte_ready_out, 1);
        end else begin
            if (emits)
                for (int i = 7; i >= 0; i--) exp_q.push_back(val[i]);
            tick();
        end
        byte_valid_in = 1'b0;
    endtask

    task automatic do_start();
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},  byte_ready_out, 0);
        check({tag, "_sval"},   serial_valid_out, 0);
        check({tag, "_serial"}, serial_out, 0);
        check({tag, "_blocks"}, block_count_out, 0);
        check({tag, "_busy"},   busy_out, 0);
        check({tag, "_done"},   done_out, 0);
        check({tag, "_error"},  error_out, 0);
        check({tag, "_resync"}, resync_out, 0);
    endtask

    // Serial monitor: pops the scoreboard, checks run length and idle level.
    always @(negedge clk_in) begin
        cyc++;
        if (rst_in) begin
            run = 0;
        end else begin
            if (resync_out) resync_cnt++;
            if (serial_valid_out) begin
                if (exp_q.size() == 0) begin
                    check("serial_unexpected", serial_valid_out, 0);
                end else begin
                    check("serial_bit", serial_out, exp_q.pop_front());
                end
                run++;
                if (run == 1) first_q.push_back(cyc);
            end else begin
                if (run != 0) check("serial_run_len", run, 8);
                run = 0;
                check("serial_idle_zero", serial_out, 0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt;
        vecs[0] = '{8'hA5, 1'b1, 8'hA5};
        vecs[1] = '{8'h3C, 1'b1, 8'h3C};
        vecs[2] = '{8'hFF, 1'b0, 8'h00};
        vecs[3] = '{8'h00, 1'b1, 8'hFF};
        vecs[4] = '{8'hFF, 1'b0, 8'h00};
        vecs[5] = '{8'hFF, 1'b0, 8'h00};
        vecs[6] = '{8'hD9, 1'b0, 8'h00};

        // reset state
        repeat (3) tick();
        check_all_zero("reset");
        rst_in = 1'b0;
        tick();

        // data, stuffing, fill byte and EOI
        do_start();
        check("start_busy", busy_out, 1);
        check("start_ready", byte_ready_out, 1);
        first_q.delete();
        foreach (vecs[i]) send_byte(vecs[i].b, vecs[i].emits, vecs[i].val);
        check("stream_drained", exp_q.size(), 0);
        check("stream_bytes_out", first_q.size(), 3);
        if (first_q.size() >= 2)
            check("byte_spacing", first_q[1] - first_q[0], 9);
        check("drain_busy", busy_out, 1);
        check("drain_done", done_out, 0);
        check("drain_error", error_out, 0);
        check("drain_ready", byte_ready_out, 0);

        // 16 rows in DRAIN -> two blocks -> DONE
        row_valid_in = 1'b1;
        repeat (8) tick();
        check("blocks_after_8_rows", block_count_out, 1);
        repeat (8) tick();
        row_valid_in = 1'b0;
        tick();
        check("frame_blocks", block_count_out, 2);
        check("frame_done", done_out, 1);
        check("frame_error", error_out, 0);
        check("frame_busy", busy_out, 0);

        // restart from DONE; the coincident row is discarded
        start_in = 1'b1;
        row_valid_in = 1'b1;
        tick();
        start_in = 1'b0;
        check("restart_blocks", block_count_out, 0);
        check("restart_done", done_out, 0);
        repeat (7) tick();
        check("restart_7_rows", block_count_out, 0);
        tick();
        row_valid_in = 1'b0;
        check("restart_8_rows", block_count_out, 1);

        // drain timeout; a start inside DRAIN must be ignored
        send_byte(8'h12, 1'b1, 8'h12);
        send_byte(8'hFF, 1'b0, 8'h00);
        send_byte(8'hD9, 1'b0, 8'h00);
        cnt = 0;
        while (!done_out && cnt < 100) begin
            start_in = (cnt == 10);
            tick();
            cnt++;
        end
        start_in = 1'b0;
        check("timeout_cycles", cnt, TMO);
        check("timeout_done", done_out, 1);
        check("timeout_error", error_out, 1);
        check("timeout_blocks", block_count_out, 1);

        // RSTn markers
        do_start();
        check("rst_err_cleared", error_out, 0);
        resync_cnt = 0;
        send_byte(8'hFF, 1'b0, 8'h00);
        send_byte(8'hD0, 1'b0, 8'h00);
        tick();
`ifdef JPEG_RST_MARKER_EN
        check("rst0_error", error_out, 0);
        check("rst0_pulses", resync_cnt, 1);
        check("rst0_ready", byte_ready_out, 1);
        send_byte(8'hFF, 1'b0, 8'h00);
        send_byte(8'hD2, 1'b0, 8'h00);
        tick();
        check("rst2_error", error_out, 1);
        check("rst2_pulses", resync_cnt, 2);
        check("rst2_busy", busy_out, 1);
`else
        check("rst0_error", error_out, 1);
        check("rst0_done", done_out, 1);
        check("rst0_pulses", resync_cnt, 0);
`endif

        // reset in the middle of a shifted byte
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        do_start();
        send_byte(8'hC3, 1'b1, 8'hC3);
        repeat (3) tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        exp_q.delete();
        check_all_zero("midshift_reset");
        repeat (12) tick();
        check("post_reset_idle_busy", busy_out, 0);
        check("post_reset_sval", serial_valid_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
